// File: rtl/mesh_term_src_fifo.sv
// Per-terminal source FIFO with show-ahead head word for one mesh input port.
// Counts pushes dropped while full and latches a sticky flag on pops while empty.
module mesh_term_src_fifo #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int CNT_W      = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [pckg_sz-1:0]                 data_in,
  output logic                               full,
  output logic                               pndng,
  output logic [pckg_sz-1:0]                 data_out,
  input  logic                               popin,
  output logic [$clog2(fifo_depth+1)-1:0]    count,
  output logic [CNT_W-1:0]                   overflow_cnt,
  output logic                               underflow
);

  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CCW   = $clog2(fifo_depth + 1);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CCW-1:0]     count_q;
  logic [CCW-1:0]     count_nxt;
  logic               pndng_q;
  logic               full_q;
  logic [CNT_W-1:0]   ovf_q;
  logic               unf_q;
  logic               do_pop;
  logic               do_push;
  logic               drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(fifo_depth - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) return v;
    return v + CNT_W'(1);
  endfunction

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign do_pop  = popin & pndng_q;
  assign do_push = push & (~full_q | do_pop);
  assign drop    = push & ~do_push;

  always_comb begin
    count_nxt = count_q;
    if (do_push && !do_pop)      count_nxt = count_q + CCW'(1);
    else if (do_pop && !do_push) count_nxt = count_q - CCW'(1);
  end

  // Control state; flags are registered from the next count so they carry no
  // combinational path from push or popin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      pndng_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      count_q <= count_nxt;
      pndng_q <= (count_nxt != '0);
      full_q  <= (count_nxt == CCW'(fifo_depth));
      if (drop) ovf_q <= sat_inc(ovf_q);
      if (popin && !pndng_q) unf_q <= 1'b1;
    end
  end

  // Storage is never cleared; reset only empties the FIFO logically.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  assign data_out     = pndng_q ? mem[rd_ptr] : '0;
  assign pndng        = pndng_q;
  assign full         = full_q;
  assign count        = count_q;
  assign overflow_cnt = ovf_q;
  assign underflow    = unf_q;

endmodule
